sync_fifo_flex: RTL and testbench

Parametrised synchronous FIFO, the next generation of the single-clock FIFO: configurable width and depth, programmable almost-full/almost-empty thresholds, occupancy count, selectable standard or first-word-fall-through (FWFT) read mode, and separate sticky overflow/underflow flags with a clear input. It sits between a producer and a consumer in the same clock domain and is the default buffering primitive for new datapaths.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 32 +++
 rtl/sync_fifo_flex.sv | 125 ++++++++++++
 tb/tb_sync_fifo_flex.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sync_fifo_pkg                                      |
// | Description : Shared mode constants and sizing helper for the    |
// |               synchronous FIFO.                                  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package sync_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Occupancy needs one bit more than the address so it can hold DEPTH.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fifo_mem                                           |
// | Description : Simple dual-port storage, synchronous write and    |
// |               asynchronous read.                                 |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module fifo_mem #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flex.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sync_fifo_flex                                     |
// | Description : Single-clock FIFO with thresholds, occupancy,      |
// |               sticky error flags and standard/FWFT read modes.   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [WIDTH-1:0]              wdata_i,
    input  logic                          wr_en_i,
    input  logic                          rd_en_i,
    input  logic                          err_clr_i,
    output logic [WIDTH-1:0]              rdata_o,
    output logic                          rvalid_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          afull_o,
    output logic                          aempty_o,
    output logic                          ovf_o,
    output logic                          udf_o
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = count_width(DEPTH);

    localparam logic [CNT_WIDTH-1:0] c_depth     = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_afull_th  = CNT_WIDTH'(AFULL_TH);
    localparam logic [CNT_WIDTH-1:0] c_aempty_th = CNT_WIDTH'(AEMPTY_TH);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [WIDTH-1:0]      w_mem_rdata;

    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = rd_en_i && !w_empty;
    // A full FIFO can still take a write when a read frees a slot this cycle.
    assign w_wr_acc = wr_en_i && (!w_full || w_rd_acc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + ADDR_WIDTH'(1);
            if (w_rd_acc) r_rptr <= r_rptr + ADDR_WIDTH'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en_i && !w_wr_acc) r_ovf <= 1'b1;
            else if (err_clr_i)       r_ovf <= 1'b0;
            if (rd_en_i && !w_rd_acc) r_udf <= 1'b1;
            else if (err_clr_i)       r_udf <= 1'b0;
        end
    end

    fifo_mem #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (w_wr_acc),
        .waddr_i (r_wptr),
        .wdata_i (wdata_i),
        .raddr_i (r_rptr),
        .rdata_o (w_mem_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign rdata_o  = w_empty ? '0 : w_mem_rdata;
            assign rvalid_o = !w_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_rdata;
            logic             r_rvalid;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_acc;
                    if (w_rd_acc) r_rdata <= w_mem_rdata;
                end
            end

            assign rdata_o  = r_rdata;
            assign rvalid_o = r_rvalid;
        end
    endgenerate

    assign count_o  = r_count;
    assign full_o   = w_full;
    assign empty_o  = w_empty;
    assign afull_o  = (r_count >= c_afull_th);
    assign aempty_o = (r_count <= c_aempty_th);
    assign ovf_o    = r_ovf;
    assign udf_o    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_sync_fifo_flex                                  |
// | Description : Directed self-checking bench, standard and FWFT.   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module tb_sync_fifo_flex;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata;
    logic       wr_en, rd_en, err_clr;
    logic [7:0] rdata;
    logic       rvalid, full, empty, afull, aempty, ovf, udf;
    logic [4:0] count;

    logic [7:0] f_wdata;
    logic       f_wr_en, f_rd_en, f_err_clr;
    logic [7:0] f_rdata;
    logic       f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [4:0] f_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) dut (
        .clk_i(clk), .rst_i(rst), .wdata_i(wdata), .wr_en_i(wr_en), .rd_en_i(rd_en),
        .err_clr_i(err_clr), .rdata_o(rdata), .rvalid_o(rvalid), .count_o(count),
        .full_o(full), .empty_o(empty), .afull_o(afull), .aempty_o(aempty),
        .ovf_o(ovf), .udf_o(udf)
    );

    sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) dut_fw (
        .clk_i(clk), .rst_i(rst), .wdata_i(f_wdata), .wr_en_i(f_wr_en), .rd_en_i(f_rd_en),
        .err_clr_i(f_err_clr), .rdata_o(f_rdata), .rvalid_o(f_rvalid), .count_o(f_count),
        .full_o(f_full), .empty_o(f_empty), .afull_o(f_afull), .aempty_o(f_aempty),
        .ovf_o(f_ovf), .udf_o(f_udf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({empty, aempty, full, afull, ovf, udf, rvalid} !== 7'b1100000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 1100000", {empty, aempty, full, afull, ovf, udf, rvalid});
        end
        n_vec++;
        if (count !== 5'd0 || rdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_count_data: got count=%0d rdata=%h expected 0/00", count, rdata);
        end
        n_vec++;
        if ({f_empty, f_rvalid, f_count} !== {1'b1, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL reset_fwft: got empty=%b rvalid=%b count=%0d expected 1/0/0", f_empty, f_rvalid, f_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wdata = 8'(i);
            tick();
            n_vec++;
            if (count !== 5'(i + 1) || afull !== (i + 1 >= 12) || full !== (i + 1 == 16)
                || aempty !== (i + 1 <= 4) || empty !== 1'b0) begin
                n_err++;
                $display("FAIL fill_%0d: got count=%0d afull=%b full=%b aempty=%b empty=%b expected count=%0d afull=%b full=%b aempty=%b empty=0",
                         i, count, afull, full, aempty, empty, i + 1, (i + 1 >= 12), (i + 1 == 16), (i + 1 <= 4));
            end
        end
        wdata = 8'hFF;
        tick();
        wr_en = 1'b0;
        n_vec++;
        if (ovf !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: got ovf=%b count=%0d full=%b expected 1/16/1", ovf, count, full);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_vec++;
        if (ovf !== 1'b0 || count !== 5'd16) begin
            n_err++;
            $display("FAIL ovf_clear: got ovf=%b count=%0d expected 0/16", ovf, count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            n_vec++;
            if (rvalid !== 1'b1 || rdata !== 8'(i) || count !== 5'(15 - i)) begin
                n_err++;
                $display("FAIL drain_%0d: got rvalid=%b rdata=%h count=%0d expected 1/%h/%0d",
                         i, rvalid, rdata, count, 8'(i), 15 - i);
            end
        end
        tick();
        rd_en = 1'b0;
        n_vec++;
        if (udf !== 1'b1 || rvalid !== 1'b0 || empty !== 1'b1 || rdata !== 8'h0F) begin
            n_err++;
            $display("FAIL underflow: got udf=%b rvalid=%b empty=%b rdata=%h expected 1/0/1/0f", udf, rvalid, empty, rdata);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_vec++;
        if (udf !== 1'b0) begin
            n_err++;
            $display("FAIL udf_clear: got udf=%b expected 0", udf);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wdata = 8'(8'h10 + i);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            wdata = 8'(8'h20 + i);
            tick();
            n_vec++;
            if (rdata !== 8'(8'h10 + i) || rvalid !== 1'b1 || count !== 5'd16 || ovf !== 1'b0) begin
                n_err++;
                $display("FAIL full_rw_%0d: got rdata=%h rvalid=%b count=%0d ovf=%b expected %h/1/16/0",
                         i, rdata, rvalid, count, ovf, 8'(8'h10 + i));
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_vec++;
            if (rdata !== ((i < 8) ? 8'(8'h18 + i) : 8'(8'h20 + i - 8))) begin
                n_err++;
                $display("FAIL wrap_read_%0d: got %h expected %h", i, rdata,
                         (i < 8) ? 8'(8'h18 + i) : 8'(8'h20 + i - 8));
            end
        end
        rd_en = 1'b0;
        tick();
        n_vec++;
        if (empty !== 1'b1 || udf !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_end: got empty=%b udf=%b expected 1/0", empty, udf);
        end
    endtask

    task automatic test_empty_rw();
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hA5;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_vec++;
        if (udf !== 1'b1 || count !== 5'd1 || rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL empty_rw: got udf=%b count=%0d rvalid=%b expected 1/1/0", udf, count, rvalid);
        end
        err_clr = 1'b1;
        rd_en = 1'b1;
        tick();
        err_clr = 1'b0;
        rd_en = 1'b0;
        n_vec++;
        if (rdata !== 8'hA5 || rvalid !== 1'b1 || count !== 5'd0 || udf !== 1'b0) begin
            n_err++;
            $display("FAIL empty_rw_read: got rdata=%h rvalid=%b count=%0d udf=%b expected a5/1/0/0", rdata, rvalid, count, udf);
        end
    endtask

    task automatic test_fwft();
        f_wr_en = 1'b1;
        f_wdata = 8'h3C;
        tick();
        f_wr_en = 1'b0;
        n_vec++;
        if (f_rdata !== 8'h3C || f_rvalid !== 1'b1 || f_empty !== 1'b0) begin
            n_err++;
            $display("FAIL fwft_show: got rdata=%h rvalid=%b empty=%b expected 3c/1/0", f_rdata, f_rvalid, f_empty);
        end
        tick();
        n_vec++;
        if (f_rdata !== 8'h3C || f_count !== 5'd1) begin
            n_err++;
            $display("FAIL fwft_hold: got rdata=%h count=%0d expected 3c/1", f_rdata, f_count);
        end
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        n_vec++;
        if (f_empty !== 1'b1 || f_rvalid !== 1'b0 || f_udf !== 1'b0) begin
            n_err++;
            $display("FAIL fwft_pop: got empty=%b rvalid=%b udf=%b expected 1/0/0", f_empty, f_rvalid, f_udf);
        end
    endtask

    initial begin
        rst = 1'b1;
        wdata = '0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        f_wdata = '0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_empty_rw();
        test_fwft();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
